// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, ROM addressing and IF/ID register
// Defining FETCH_PERF_CNT_EN adds saturating fetch_cnt/bubble_cnt outputs.
module if_stage #(
   parameter int AW       = 6,
   parameter int DW       = 32,
   parameter int START_PC = 1
) (
   input  logic          clk,
   input  logic          rst,
   output logic [AW-1:0] rom_addr,
   input  logic [DW-1:0] rom_inst,
   input  logic          stall,
   input  logic          redirect_valid,
   input  logic [AW-1:0] redirect_pc,
   input  logic          halt_req,
   output logic [DW-1:0] ifid_inst,
   output logic [AW-1:0] ifid_pc,
   output logic [AW-1:0] ifid_pc_next,
   output logic          ifid_valid,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]   fetch_cnt,
   output logic [31:0]   bubble_cnt,
`endif
   output logic          halted
);

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] pc;
   logic [AW-1:0] pc_inc;
   logic          do_load;
   logic          do_bubble;
   logic          do_kill;

   assign pc_inc   = pc + AW'(1);
   assign rom_addr = pc;
   assign halted   = (state == HALT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= BOOT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      do_load   = 1'b0;
      do_bubble = 1'b0;
      do_kill   = 1'b0;
      case (state)
         BOOT: state_nxt = halt_req ? HALT : RUN;
         RUN: begin
            if (halt_req) begin
               state_nxt = HALT;
               do_kill   = 1'b1;
            end else if (redirect_valid) begin
               do_bubble = 1'b1;
            end else if (!stall) begin
               do_load   = 1'b1;
            end
         end
         default: state_nxt = HALT;
      endcase
   end

   // A redirect squashes the wrong-path fetch but keeps ifid_pc/ifid_pc_next.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc           <= AW'(START_PC);
         ifid_inst    <= '0;
         ifid_pc      <= '0;
         ifid_pc_next <= '0;
         ifid_valid   <= 1'b0;
      end else if (do_load) begin
         ifid_inst    <= rom_inst;
         ifid_pc      <= pc;
         ifid_pc_next <= pc_inc;
         ifid_valid   <= 1'b1;
         pc           <= pc_inc;
      end else if (do_bubble) begin
         pc           <= redirect_pc;
         ifid_inst    <= '0;
         ifid_valid   <= 1'b0;
      end else if (do_kill) begin
         ifid_inst    <= '0;
         ifid_valid   <= 1'b0;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (do_load && (fetch_cnt != 32'hFFFF_FFFF))
            fetch_cnt <= fetch_cnt + 32'd1;
         if (do_bubble && (bubble_cnt != 32'hFFFF_FFFF))
            bubble_cnt <= bubble_cnt + 32'd1;
      end
   end
`endif

endmodule
